// File: rtl/reg_file_mp.sv
// Two-read, one-write register file with write-first bypass and a
// sequential clear sweep that zeroes one register per clock.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy
);
    // state | meaning
    // IDLE  | normal read/write operation
    // CLEAR | sweeping regs[cnt] to zero, writes and bypass disabled
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_zero;
    logic              wr_ok;

    assign busy    = (state == CLEAR);
    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
    assign wr_ok   = we && !busy && !wr_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req)     state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cnt sits at zero outside a sweep, so entering CLEAR starts at register 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              cnt <= '0;
        else if (state == CLEAR && cnt != LAST)  cnt <= cnt + ADDR_W'(1);
        else                                     cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (busy) begin
            regs[cnt] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0)) return '0;
        else if (wr_ok && (addr == waddr))   return wdata;
        else                                 return regs[addr];
    endfunction

    assign rdata_a = read_port(raddr_a);
    assign rdata_b = read_port(raddr_b);

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, 0 = register 0 is ordinary storage.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 we  input  1  write enable.
REQ-007 waddr  input  ADDR_W  write address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 raddr_a  input  ADDR_W  read port A address.
REQ-010 raddr_b  input  ADDR_W  read port B address.
REQ-011 rdata_a  output  DATA_W  read port A data, combinational.
REQ-012 rdata_b  output  DATA_W  read port B data, combinational.
REQ-013 clr_req  input  1  one-cycle request to start a sequential clear of all registers.
REQ-014 busy  output  1  high while a clear sweep is in progress.

Function
REQ-015 Write: on rising clk with we=1 and busy=0, register[waddr] SHALL take wdata; one-cycle write latency.
REQ-016 With ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 on both ports.
REQ-017 Read: each port SHALL return register[raddr] combinationally, with zero added latency.
REQ-018 Bypass: when we=1, busy=0, raddr==waddr, and the address is not a hardwired zero register, the port SHALL return wdata in the same cycle (write-first).
REQ-019 Both ports reading the same address SHALL return identical data, bypass included.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR; busy = (state==CLEAR).
REQ-021 In IDLE, clr_req=1 at a rising edge SHALL move the FSM to CLEAR and load the sweep counter cnt with 0.
REQ-022 In CLEAR, each rising edge SHALL zero register[cnt] and increment cnt.
REQ-023 When cnt==DEPTH-1 the FSM SHALL zero that register and return to IDLE, so busy stays high for exactly DEPTH cycles.
REQ-024 cnt SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 within a sweep.
REQ-025 In CLEAR, we SHALL be ignored (write dropped) and bypass disabled.
REQ-026 In CLEAR, reads SHALL return current contents: already-swept registers read 0, unswept registers read their old value.
REQ-027 clr_req in CLEAR SHALL be ignored; the sweep neither restarts nor extends.
REQ-028 clr_req and we asserted together in IDLE: the write SHALL complete on that edge; the sweep starts next cycle and clears it.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously set all registers to 0, state to IDLE, cnt to 0 and busy to 0, regardless of clk.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; after deassertion the FSM is in IDLE with all registers 0.
REQ-031 After reset, rdata_a and rdata_b SHALL read 0 for every address until written.
REQ-032 Operation SHALL resume on the first rising clk after rst_n goes high.

Verification
REQ-033 Reset then write 0xDEADBEEF to addr 5, next cycle read A=5, B=5 -> both 0xDEADBEEF.
REQ-034 we=1, waddr=7, wdata=0x12345678, raddr_a=7 in same cycle -> rdata_a=0x12345678 before the edge (bypass).
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> rdata 0; ZERO_REG=0 -> rdata 0xFFFFFFFF.
REQ-036 Fill regs 1..31 with their index, pulse clr_req -> busy high for exactly 32 cycles; reg 31 reads 31 at cycle 10, all regs 0 afterwards; write to addr 3 during busy is dropped.
REQ-037 Pulse rst_n low at cycle 12 of a sweep with regs pre-filled -> busy=0 immediately, all regs read 0, next write to addr 9 succeeds.
REQ-038 DATA_W=64, ADDR_W=3: write 0x0123456789ABCDEF to addr 6 -> read back exact value; clear sweep lasts 8 cycles.
